// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-client arbiter/sequencer for a single-port synchronous SRAM.
//               Round-robin by default; SRAM_ARB_FIXED_PRIO_EN selects fixed
//               priority (port 0 always wins a tie).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACC     = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;

    logic [1:0]            r_state;
    logic                  r_win;
    logic                  r_rd;
    logic                  w_any;
    logic                  w_win;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_any = req0 | req1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign w_win = ~req0;
`else
    logic r_last;

    // Tie goes to whichever port did not win last; reset value favours port 0.
    assign w_win = (req0 & req1) ? ~r_last : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_any) begin
            r_last <= w_win;
        end
    end
`endif

    assign w_we    = w_win ? we1    : we0;
    assign w_addr  = w_win ? addr1  : addr0;
    assign w_wdata = w_win ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_win     <= 1'b0;
            r_rd      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        sram_en   <= 1'b1;
                        sram_we   <= w_we;
                        sram_addr <= w_addr;
                        sram_din  <= w_wdata;
                        gnt0      <= ~w_win;
                        gnt1      <= w_win;
                        r_win     <= w_win;
                        r_rd      <= ~w_we;
                        r_state   <= S_ACC;
                    end
                end
                S_ACC: begin
                    // The SRAM performs the access on the edge that leaves this state.
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    sram_en <= 1'b0;
                    r_state <= r_rd ? S_RD_WAIT : S_IDLE;
                end
                S_RD_WAIT: begin
                    if (r_win) begin
                        rdata1  <= sram_dout;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= sram_dout;
                        rvalid0 <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Scoreboard bench for sram_arbiter with a behavioural SRAM and a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, rvalid0, gnt1, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout = '0;

    sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port synchronous SRAM (read-first)
    logic [DW-1:0] smem [16];
    initial for (int i = 0; i < 16; i++) smem[i] = '0;
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) smem[sram_addr] <= sram_din;
            sram_dout <= smem[sram_addr];
        end
    end

    typedef struct {
        int            port;
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } gexp_t;

    typedef struct {
        int            port;
        int            cyc;
        logic [DW-1:0] data;
    } rexp_t;

    gexp_t         gq[$];
    rexp_t         rq[$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] ref_rdata [2];
    int            last_win = 1;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s @cyc %0d", name, cyc);
    endtask

    // Reference arbitration decision from the set of requesting ports
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return 1 - last_win;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    // Serialise one transaction in grant order; g is the cycle its grant is visible
    function automatic void push_txn(input int p, input logic we, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input int g);
        gexp_t e;
        rexp_t r;
        e.port = p; e.cyc = g; e.we = we; e.addr = a; e.din = d;
        gq.push_back(e);
        if (we) begin
            ref_mem[a] = d;
        end else begin
            r.port = p; r.cyc = g + 2; r.data = ref_mem[a];
            rq.push_back(r);
        end
        last_win = p;
    endfunction

    // Monitor: compares every grant and rvalid against the scoreboard queues
    initial begin
        gexp_t e;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (gnt0 === 1'b1 && gnt1 === 1'b1) flag("both_gnt");
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                if (gq.size() == 0) begin
                    flag("unexpected_gnt");
                end else begin
                    e = gq.pop_front();
                    check("gnt_port", 64'(gnt1), 64'(e.port));
                    check("gnt_cycle", 64'(cyc), 64'(e.cyc));
                    check("sram_en", 64'(sram_en), 64'd1);
                    check("sram_we", 64'(sram_we), 64'(e.we));
                    check("sram_addr", 64'(sram_addr), 64'(e.addr));
                    if (e.we) check("sram_din", 64'(sram_din), 64'(e.din));
                end
            end
            if (rvalid0 === 1'b1 && rvalid1 === 1'b1) flag("both_rvalid");
            if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
                if (rq.size() == 0) begin
                    flag("unexpected_rvalid");
                end else begin
                    r = rq.pop_front();
                    check("rvalid_port", 64'(rvalid1), 64'(r.port));
                    check("rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    check("rdata", 64'(r.port == 1 ? rdata1 : rdata0), 64'(r.data));
                    check("rdata_other_held", 64'(r.port == 1 ? rdata0 : rdata1),
                          64'(ref_rdata[1 - r.port]));
                    ref_rdata[r.port] = r.data;
                end
            end
        end
    end

    // Inputs are driven 2 time units after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_round(input bit r0, input bit r1,
                            input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                            input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        int  k, w, g;
        bit  ok;
        ok = 0;
        we0 = w0; addr0 = a0; wdata0 = d0; req0 = r0;
        we1 = w1; addr1 = a1; wdata1 = d1; req1 = r1;
        k = cyc;
        w = pick(r0, r1);
        g = k + 1;
        if (w == 0) push_txn(0, w0, a0, d0, g);
        else        push_txn(1, w1, a1, d1, g);
        if (r0 && r1) begin
            g = g + (((w == 0) ? w0 : w1) ? 2 : 3);
            if (w == 0) push_txn(1, w1, a1, d1, g);
            else        push_txn(0, w0, a0, d0, g);
        end
        for (int t = 0; t < 40; t++) begin
            step();
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if (!req0 && !req1 && gq.size() == 0 && rq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            flag("round_timeout");
            req0 = 1'b0; req1 = 1'b0;
            gq.delete(); rq.delete();
        end
    endtask

    task automatic cont_reads(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        int k, seen;
        bit ok;
        ok = 0; seen = 0;
        we0 = 1'b0; addr0 = a0; we1 = 1'b0; addr1 = a1;
        req0 = 1'b1; req1 = 1'b1;
        k = cyc;
        for (int i = 0; i < n; i++) begin
            int w;
            w = pick(1, 1);
            push_txn(w, 1'b0, (w == 1) ? a1 : a0, '0, k + 1 + 3 * i);
        end
        for (int t = 0; t < 200; t++) begin
            step();
            if (gnt0 || gnt1) begin
                seen++;
                if (seen == n) begin
                    req0 = 1'b0; req1 = 1'b0;
                end
            end
            if (!req0 && !req1 && gq.size() == 0 && rq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            flag("cont_timeout");
            req0 = 1'b0; req1 = 1'b0;
            gq.delete(); rq.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
                         sram_en, sram_we, sram_addr, sram_din}), 64'd0);
    endtask

    initial begin
        gexp_t e;
        bit    ok;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;

        rst = 1'b1;
        repeat (3) step();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        step();

        // Simultaneous writes, then read-back of each
        do_round(1, 1, 1'b1, 4'h3, 8'h11, 1'b1, 4'h7, 8'h22);
        do_round(1, 0, 1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00);
        do_round(1, 0, 1'b0, 4'h7, 8'h00, 1'b0, 4'h0, 8'h00);
        // Port 0 write/read, port 1 write/read at the top address
        do_round(1, 0, 1'b1, 4'h3, 8'hA5, 1'b0, 4'h0, 8'h00);
        do_round(1, 0, 1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00);
        do_round(0, 1, 1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 8'h3C);
        do_round(0, 1, 1'b0, 4'h0, 8'h00, 1'b0, 4'hF, 8'h00);
        // Continuous contention from both ports
        cont_reads(6, 4'h3, 4'hF);

        // Reset landing in the RD_WAIT cycle of a port 0 read
        we0 = 1'b0; addr0 = 4'h3; req0 = 1'b1; req1 = 1'b0;
        e.port = 0; e.cyc = cyc + 1; e.we = 1'b0; e.addr = 4'h3; e.din = '0;
        gq.push_back(e);
        ok = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (gnt0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) flag("rst_test_gnt_timeout");
        req0 = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_all_zero("rst_in_rd_wait");
        check("rst_no_rvalid0", 64'(rvalid0), 64'd0);
        rst = 1'b0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        last_win = 1;
        gq.delete(); rq.delete();
        step();
        do_round(1, 0, 1'b0, 4'h3, 8'h00, 1'b0, 4'h0, 8'h00);
        do_round(1, 1, 1'b0, 4'h7, 8'h00, 1'b0, 4'h3, 8'h00);

        // Randomised traffic
        for (int i = 0; i < 120; i++) begin
            int m;
            m = $urandom_range(1, 3);
            do_round(m[0], m[1],
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end
        cont_reads(5, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        repeat (4) step();
        if (gq.size() != 0 || rq.size() != 0) flag("leftover_expectations");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
